// File: rtl/instr_issuer_if.sv
// instr_issuer_if: host write port, run control and issue-side outputs of the instruction issuer
interface instr_issuer_if #(
   parameter int DEPTH = 8,
   parameter int CODE_W = 23
);
   logic wr_en;
   logic [CODE_W-1:0] wr_code;
   logic full;
   logic [$clog2(DEPTH):0] count;
   logic run;
   logic [CODE_W-1:0] code;
   logic code_valid;
   logic busy;
   logic done;
   logic illegal;
   logic [7:0] issued;
   modport master (
      output wr_en, wr_code, run,
      input full, count, code, code_valid, busy, done, illegal, issued
   );
   modport slave (
      input wr_en, wr_code, run,
      output full, count, code, code_valid, busy, done, illegal, issued
   );
endinterface

// File: rtl/instr_issuer.sv
// instr_issuer: program FIFO feeding code words to the control FSM, each held for its opcode's
// cycle count and followed by a one-cycle all-zero gap.
module instr_issuer #(
   parameter int DEPTH = 8,
   parameter int CODE_W = 23
) (
   input logic clk,
   input logic reset,
   instr_issuer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, GAP = 2'd2;
   logic [CODE_W-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0] cnt;
   logic [1:0] state, hcnt, hold;
   logic [CODE_W-1:0] code_r;
   logic ill_r;
   logic [7:0] issued_r;
   logic [3:0] func;
   logic legal, wr_ok, pop;
   always_comb begin
      func = mem[rp][CODE_W-1 -: 4];
      legal = func >= 4'd1 && func <= 4'd9;
      hold = func <= 4'd2 ? 2'd0 : 2'd2;
      wr_ok = bus.wr_en && cnt != FULL_CNT;
      pop = (state == IDLE || state == GAP) && bus.run && cnt != '0;
   end
   always_ff @(posedge clk)
      if (wr_ok) mem[wp] <= bus.wr_code;
   always_ff @(posedge clk) begin
      if (reset) begin
         wp <= '0;
         rp <= '0;
         cnt <= '0;
         state <= IDLE;
         hcnt <= '0;
         code_r <= '0;
         ill_r <= 1'b0;
         issued_r <= '0;
      end else begin
         ill_r <= pop && !legal;
         if (wr_ok) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         cnt <= cnt + (AW+1)'(wr_ok) - (AW+1)'(pop);
         if (state == GAP) issued_r <= issued_r + 8'd1;
         // hcnt holds remaining ISSUE cycles minus one; illegal pops fall through to IDLE
         if (pop && legal) begin
            code_r <= mem[rp];
            hcnt <= hold;
            state <= ISSUE;
         end else if (state == ISSUE) begin
            hcnt <= hcnt - 2'd1;
            if (hcnt == 2'd0) state <= GAP;
         end else
            state <= IDLE;
      end
   end
   always_comb begin
      bus.full = cnt == FULL_CNT;
      bus.count = cnt;
      bus.code = state == ISSUE ? code_r : '0;
      bus.code_valid = state == ISSUE;
      bus.busy = state != IDLE;
      bus.done = state == GAP;
      bus.illegal = ill_r;
      bus.issued = issued_r;
   end
endmodule

// File: tb/tb_instr_issuer.sv
// tb_instr_issuer: directed scenarios plus randomized traffic checked every cycle against
// a queue-based model of the FIFO and the per-instruction output script.
module tb_instr_issuer;
   localparam int DEPTH = 8;
   typedef struct {
      logic [22:0] c;
      bit v;
   } ent_t;
   logic clk = 0;
   logic reset = 1;
   int total = 0, bad = 0;
   instr_issuer_if #(.DEPTH(DEPTH), .CODE_W(23)) bus();
   instr_issuer #(.DEPTH(DEPTH), .CODE_W(23)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;

   logic [22:0] q[$];
   ent_t s[$];
   bit m_ill = 0, armed = 0;
   int m_issued = 0;
   bit full_b, in_gap, pop_m;
   logic [22:0] w;
   int f;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Each legal pop appends its whole output script: hold cycles of the word, then one gap.
   always @(posedge clk) begin
      armed = 1;
      if (reset) begin
         q.delete();
         s.delete();
         m_ill = 0;
         m_issued = 0;
      end else begin
         full_b = q.size() == DEPTH;
         in_gap = s.size() > 0 && !s[0].v;
         pop_m = (s.size() == 0 || in_gap) && bus.run && q.size() > 0;
         if (s.size() > 0) s.delete(0);
         if (in_gap) m_issued = (m_issued + 1) % 256;
         m_ill = 0;
         if (pop_m) begin
            w = q.pop_front();
            f = int'(w[22:19]);
            if (f >= 1 && f <= 9) begin
               repeat (f <= 2 ? 1 : 3) s.push_back('{w, 1'b1});
               s.push_back('{23'd0, 1'b0});
            end else
               m_ill = 1;
         end
         if (bus.wr_en && !full_b) q.push_back(bus.wr_code);
      end
   end

   always @(negedge clk) if (armed) begin
      check("code", 32'(bus.code), (s.size() > 0 && s[0].v) ? 32'(s[0].c) : 32'd0);
      check("code_valid", 32'(bus.code_valid), 32'(s.size() > 0 && s[0].v));
      check("busy", 32'(bus.busy), 32'(s.size() > 0));
      check("done", 32'(bus.done), 32'(s.size() > 0 && !s[0].v));
      check("illegal", 32'(bus.illegal), 32'(m_ill));
      check("issued", 32'(bus.issued), 32'(m_issued));
      check("count", 32'(bus.count), 32'(q.size()));
      check("full", 32'(bus.full), 32'(q.size() == DEPTH));
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wr(logic [22:0] word);
      bus.wr_en = 1;
      bus.wr_code = word;
      tick();
      bus.wr_en = 0;
   endtask

   initial begin
      int bc, vc, ill, bad_seen;
      logic [22:0] got[$];
      bus.wr_en = 0;
      bus.wr_code = 0;
      bus.run = 0;
      repeat (3) tick();
      reset = 0;
      // single load
      wr(23'h080005);
      check("t1 count", 32'(bus.count), 32'd1);
      bus.run = 1;
      tick();
      check("t1 code", 32'(bus.code), 32'h080005);
      tick();
      check("t1 done", 32'(bus.done), 32'd1);
      check("t1 gap code", 32'(bus.code), 32'd0);
      tick();
      check("t1 issued", 32'(bus.issued), 32'd1);
      check("t1 busy", 32'(bus.busy), 32'd0);
      check("t1 empty", 32'(bus.count), 32'd0);
      bus.run = 0;
      // add, sub, move back to back
      wr(23'h180011);
      wr(23'h200022);
      wr(23'h100033);
      bus.run = 1;
      bc = 0;
      vc = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         bc += int'(bus.busy);
         vc += int'(bus.code_valid);
      end
      check("t2 busy cycles", 32'(bc), 32'd10);
      check("t2 valid cycles", 32'(vc), 32'd7);
      check("t2 issued", 32'(bus.issued), 32'd4);
      bus.run = 0;
      // overfill
      for (int i = 0; i < 8; i++) wr(23'h080100 + 23'(i));
      check("t3 full", 32'(bus.full), 32'd1);
      wr(23'h0801ff);
      check("t3 count", 32'(bus.count), 32'd8);
      bus.run = 1;
      for (int i = 0; i < 24; i++) begin
         tick();
         if (bus.code_valid) got.push_back(bus.code);
      end
      check("t3 n issued", 32'(got.size()), 32'd8);
      for (int i = 0; i < got.size() && i < 8; i++) check("t3 order", 32'(got[i]), 32'h080100 + 32'(i));
      check("t3 issued", 32'(bus.issued), 32'd12);
      bus.run = 0;
      // illegal func then load
      wr(23'h780000);
      wr(23'h080007);
      bus.run = 1;
      ill = 0;
      bad_seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         ill += int'(bus.illegal);
         if (bus.code == 23'h780000) bad_seen++;
      end
      check("t4 illegal pulses", 32'(ill), 32'd1);
      check("t4 bad on code", 32'(bad_seen), 32'd0);
      check("t4 issued", 32'(bus.issued), 32'd13);
      bus.run = 0;
      // run dropped mid xor
      wr(23'h280003);
      wr(23'h080001);
      wr(23'h080002);
      bus.run = 1;
      tick();
      tick();
      check("t5 2nd issue", 32'(bus.code), 32'h280003);
      bus.run = 0;
      repeat (3) tick();
      check("t5 idle", 32'(bus.busy), 32'd0);
      check("t5 queued", 32'(bus.count), 32'd2);
      check("t5 issued", 32'(bus.issued), 32'd14);
      bus.run = 1;
      repeat (6) tick();
      check("t5 resumed", 32'(bus.issued), 32'd16);
      bus.run = 0;
      // reset mid divide
      wr(23'h400009);
      wr(23'h080003);
      bus.run = 1;
      tick();
      tick();
      check("t6 2nd issue", 32'(bus.code_valid), 32'd1);
      reset = 1;
      tick();
      check("t6 code", 32'(bus.code), 32'd0);
      check("t6 valid", 32'(bus.code_valid), 32'd0);
      check("t6 busy", 32'(bus.busy), 32'd0);
      check("t6 count", 32'(bus.count), 32'd0);
      check("t6 issued", 32'(bus.issued), 32'd0);
      reset = 0;
      bus.run = 0;
      // random traffic
      for (int i = 0; i < 3000; i++) begin
         bus.wr_en = ((i / 500) % 2) != 0 ? ($urandom % 2) == 0 : ($urandom % 5) == 0;
         bus.wr_code = {4'($urandom % 16), 19'($urandom)};
         bus.run = ($urandom % 4) != 0;
         reset = ($urandom % 400) == 0;
         tick();
      end
      reset = 0;
      bus.wr_en = 0;
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/instr_issuer.md
# instr_issuer

Instruction issue unit that feeds 23-bit code words to the processor control FSM. A host loads an 8-entry program FIFO. The issuer then pops each word and presents it on `code` for exactly the number of cycles the control FSM needs for that opcode. It follows each instruction with a one-cycle all-zero gap, which sends the control FSM back to state 0 before the next word.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; must be a power of two.
- `CODE_W`, 23: code word width. Field layout: func = [22:19], in1 = [18:16], in2 = [15:13], immediate = [15:0].

Ports:
- `clk`, in, 1: sole clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high; clears all state.
- `wr_en`, in, 1: host write strobe.
- `wr_code`, in, 23: code word to enqueue.
- `full`, out, 1: FIFO holds DEPTH entries.
- `count`, out, 4: FIFO occupancy, 0..DEPTH.
- `run`, in, 1: level-sensitive enable for issuing.
- `code`, out, 23: word presented to the control FSM; 0 whenever `code_valid` = 0.
- `code_valid`, out, 1: high while an instruction is being held on `code`.
- `busy`, out, 1: high in ISSUE or GAP.
- `done`, out, 1: one-cycle pulse in the GAP cycle after each issued instruction.
- `illegal`, out, 1: one-cycle pulse when a popped word has an undefined func.
- `issued`, out, 8: count of completed instructions; wraps 255 -> 0.

## Operation
- Defined funcs and their hold cycles:
  - 0001 load: 1 cycle.
  - 0010 move: 1 cycle.
  - 0011 add, 0100 sub, 0101 xor, 0110 or, 0111 and, 1000 divide, 1001 modulo: 3 cycles each.
  - All other funcs (0000, 1010-1111) are illegal.
- FIFO:
  - A write is accepted when `wr_en` = 1 and `full` = 0.
  - A write while full is dropped silently, even if a pop happens in the same cycle.
  - Simultaneous accepted write and pop leaves `count` unchanged.
  - A word written into an empty FIFO cannot be popped in the cycle it is written.
- FSM states:
  - IDLE:
    - Outputs: `code` = 0, `code_valid` = 0, `busy` = 0.
    - If `run` = 1 and `count` > 0: pop the head word.
    - Legal func: latch the word into the code register, load the hold counter with hold-1, go to ISSUE.
    - Illegal func: discard the word, pulse `illegal` on the next cycle, stay in IDLE.
  - ISSUE:
    - Outputs: `code_valid` = 1, `code` = latched word.
    - Hold counter decrements each cycle; at 0 go to GAP.
  - GAP:
    - Outputs: `code` = 0, `code_valid` = 0, `done` = 1.
    - `issued` increments on exit from GAP.
    - If `run` = 1 and `count` > 0: pop the next word with the same legal/illegal rules as IDLE. Legal goes to ISSUE; illegal goes to IDLE with an `illegal` pulse.
    - Otherwise go to IDLE.
- `run` dropping mid-instruction: the current ISSUE/GAP sequence completes normally, then the FSM goes to IDLE. No new pop happens while `run` = 0.
- Reset (including mid-instruction):
  - Next cycle: FSM in IDLE, FIFO empty, `count` = 0, `full` = 0.
  - `code` = 0, `code_valid` = 0, `busy` = 0, `done` = 0, `illegal` = 0, `issued` = 0.
  - An in-flight instruction is abandoned and does not count toward `issued`.

## Timing
- Write at edge t: `count` reflects the new word at t+1.
- Pop at edge t (from IDLE or GAP):
  - `code_valid` = 1 from cycle t+1 through t+hold.
  - GAP at cycle t+hold+1, with `done` = 1.
- Back-to-back throughput, FIFO non-empty and `run` = 1:
  - load/move: one instruction every 2 cycles.
  - ALU ops: one instruction every 4 cycles.
- `code` is stable (registered) for the whole ISSUE window; it never changes mid-hold.
- `illegal` asserts in the cycle after the pop of the offending word.
- `full` and `count` are registered and consistent in the same cycle.

## Test plan
- Reset, then write 0x080005 (load; func = 0001, immediate = 5), then `run` = 1:
  - `code` = 0x080005 for 1 cycle, then `done` = 1 with `code` = 0.
  - `issued` = 1; IDLE with `count` = 0.
- Enqueue add, then sub, then move; hold `run` = 1:
  - `code_valid` widths are 3, 3, 1 cycles, each followed by a 1-cycle zero gap.
  - `issued` = 3; total 10 cycles from the first `code_valid` to the end of the last GAP.
- Write 9 words with `run` = 0:
  - `full` = 1 after 8 writes; the 9th is dropped; `count` = 8.
  - With `run` = 1, exactly 8 instructions issue, in order.
- Enqueue func 1111, then load:
  - `illegal` pulses once; the bad word never appears on `code`.
  - The load issues next; `issued` = 1.
- Drop `run` in the 2nd ISSUE cycle of an xor:
  - The xor completes its 3 cycles and GAP.
  - No further pops; remaining entries stay queued; re-raising `run` resumes issue.
- Assert `reset` in the 2nd ISSUE cycle of a divide:
  - Next cycle: `code` = 0, `code_valid` = 0, `busy` = 0, `count` = 0, `issued` = 0.
